// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter that lends a single AES decryption core to NUM_REQ requesters,
// sequencing key settle, START/DONE, response handshake and core release.
module aes_core_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int KEY_SETTLE  = 12,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [128*NUM_REQ-1:0]   req_key_i,
  input  logic [128*NUM_REQ-1:0]   req_msg_i,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  input  logic [NUM_REQ-1:0]       rsp_ready_i,
  output logic [127:0]             rsp_msg_o,
  output logic                     rsp_err_o,
  output logic                     aes_start_o,
  input  logic                     aes_done_i,
  output logic [127:0]             aes_key_o,
  output logic [127:0]             aes_msg_enc_o,
  input  logic [127:0]             aes_msg_dec_i,
  output logic                     busy_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int SET_W = (KEY_SETTLE > 0) ? $clog2(KEY_SETTLE + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'((KEY_SETTLE > 0) ? KEY_SETTLE - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_MAX     = IDX_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_RESPOND,
    S_RELEASE
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_q, owner_q;
  logic [SET_W-1:0]   settle_q;
  logic [TMO_W-1:0]   tmo_q;
  logic [127:0]       aes_key_q, aes_msg_q, rsp_msg_q;
  logic               rsp_err_q;

  logic               grant_found;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   rr_next;
  logic [127:0]       grant_key, grant_msg;
  logic               accept;

  // Lowest valid index at or above rr_q wins; otherwise the lowest valid index overall (wrap).
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid_i[i] && (IDX_W'(i) >= rr_q)) begin
        grant_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    grant_key = '0;
    grant_msg = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        grant_key = req_key_i[128*i +: 128];
        grant_msg = req_msg_i[128*i +: 128];
      end
    end
  end

  assign rr_next = (grant_idx == IDX_MAX) ? '0 : grant_idx + IDX_W'(1);
  assign accept  = (state_q == S_IDLE) && grant_found;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (grant_found) state_d = (KEY_SETTLE == 0) ? S_RUN : S_LAUNCH;
      S_LAUNCH:  if (settle_q == SETTLE_LAST) state_d = S_RUN;
      S_RUN:     if (aes_done_i || (tmo_q == TMO_LAST)) state_d = S_RESPOND;
      S_RESPOND: if (rsp_ready_i[owner_q]) state_d = S_RELEASE;
      S_RELEASE: if (!aes_done_i) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = accept ? (NUM_REQ'(1) << grant_idx) : '0;
    rsp_valid_o = (state_q == S_RESPOND) ? (NUM_REQ'(1) << owner_q) : '0;
    aes_start_o = (state_q == S_RUN);
    busy_o      = (state_q != S_IDLE);
  end

  // DONE is checked before the timeout so a completion on the last allowed cycle still wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q      <= '0;
      owner_q   <= '0;
      settle_q  <= '0;
      tmo_q     <= '0;
      aes_key_q <= '0;
      aes_msg_q <= '0;
      rsp_msg_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (accept) begin
        owner_q   <= grant_idx;
        rr_q      <= rr_next;
        aes_key_q <= grant_key;
        aes_msg_q <= grant_msg;
        settle_q  <= '0;
        tmo_q     <= '0;
      end
      if (state_q == S_LAUNCH) begin
        settle_q <= settle_q + SET_W'(1);
      end
      if (state_q == S_RUN) begin
        tmo_q <= tmo_q + TMO_W'(1);
        if (aes_done_i) begin
          rsp_msg_q <= aes_msg_dec_i;
          rsp_err_q <= 1'b0;
        end else if (tmo_q == TMO_LAST) begin
          rsp_msg_q <= '0;
          rsp_err_q <= 1'b1;
        end
      end
    end
  end

  assign aes_key_o     = aes_key_q;
  assign aes_msg_enc_o = aes_msg_q;
  assign rsp_msg_o     = rsp_msg_q;
  assign rsp_err_o     = rsp_err_q;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Scoreboard bench for aes_core_arbiter: a behavioural core model, a round-robin reference
// and a negedge monitor that compares grants, timing and responses against queued expectations.
module tb_aes_core_arbiter;
  localparam int N  = 4;
  localparam int KS = 12;
  localparam int TO = 16;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid_i;
  logic [N-1:0]     req_ready_o;
  logic [128*N-1:0] req_key_i;
  logic [128*N-1:0] req_msg_i;
  logic [N-1:0]     rsp_valid_o;
  logic [N-1:0]     rsp_ready_i;
  logic [127:0]     rsp_msg_o;
  logic             rsp_err_o;
  logic             aes_start_o;
  logic             aes_done_i;
  logic [127:0]     aes_key_o;
  logic [127:0]     aes_msg_enc_o;
  logic [127:0]     aes_msg_dec_i;
  logic             busy_o;

  aes_core_arbiter #(.NUM_REQ(N), .KEY_SETTLE(KS), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_key_i(req_key_i), .req_msg_i(req_msg_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_msg_o(rsp_msg_o), .rsp_err_o(rsp_err_o),
    .aes_start_o(aes_start_o), .aes_done_i(aes_done_i),
    .aes_key_o(aes_key_o), .aes_msg_enc_o(aes_msg_enc_o), .aes_msg_dec_i(aes_msg_dec_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int coreLat   = 2;
  int coreHold  = 0;
  int rspDelay  = 0;
  bit neverDone = 1'b0;
  bit dropEn    = 1'b0;

  typedef struct {
    int           owner;
    logic [127:0] key;
    logic [127:0] msg;
    logic [127:0] plain;
    logic         err;
    int           runLen;
  } exp_t;

  exp_t expQ[$];

  // Stand-in decryption: the real FIPS-197 answer for its vector, a keyed scramble otherwise.
  function automatic logic [127:0] refPlain(input logic [127:0] k, input logic [127:0] c);
    if (k == FIPS_KEY && c == FIPS_CT) return FIPS_PT;
    return c ^ {k[63:0], k[127:64]} ^ 128'h5a5a_0f0f_c3c3_9696_a5a5_f0f0_3c3c_6969;
  endfunction

  function automatic int rrPick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      int idx = (p + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Core model: DONE after coreLat RUN cycles, held while START is high plus coreHold cycles.
  int latCnt  = 0;
  int holdCnt = 0;
  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      aes_done_i = 1'b0; aes_msg_dec_i = '0; latCnt = 0; holdCnt = 0;
    end else if (aes_start_o) begin
      holdCnt = 0;
      if (!aes_done_i && !neverDone) begin
        if (latCnt >= coreLat) begin
          aes_done_i    = 1'b1;
          aes_msg_dec_i = refPlain(aes_key_o, aes_msg_enc_o);
        end else begin
          latCnt++;
        end
      end
    end else begin
      latCnt = 0;
      if (aes_done_i) begin
        if (holdCnt >= coreHold) begin
          aes_done_i = 1'b0; aes_msg_dec_i = '0;
        end else begin
          holdCnt++;
        end
      end
    end
  end

  // Response consumer: owner bit accepted after rspDelay cycles, noise on the other bits.
  int rspWait = 0;
  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      rsp_ready_i = '0; rspWait = 0;
    end else if (rsp_valid_o != '0) begin
      rsp_ready_i = (N'($urandom) & ~rsp_valid_o) | ((rspWait >= rspDelay) ? rsp_valid_o : '0);
      rspWait++;
    end else begin
      rsp_ready_i = N'($urandom);
      rspWait = 0;
    end
  end

  // Reference model: the arbiter is free until it grants, then stays taken until the
  // response is consumed and the core has dropped DONE.
  bit           free = 1'b1;
  bit           draining = 1'b0;
  bit           startPrev = 1'b0;
  bit           inResp = 1'b0;
  int           rr = 0;
  int           grantCyc = 0;
  int           runCnt = 0;
  logic [127:0] capMsg;
  logic         capErr;

  always @(negedge clk) begin : monitor
    int           pick;
    logic [N-1:0] expReady;
    logic [N-1:0] expValid;
    exp_t         e;
    if (!rst_n) begin
      free = 1'b1; draining = 1'b0; rr = 0; expQ.delete();
      startPrev = 1'b0; inResp = 1'b0; runCnt = 0;
    end else begin
      cyc++;
      pick = rrPick(req_valid_i, rr);
      expReady = '0;
      if (free && pick >= 0) expReady[pick] = 1'b1;
      checkOutput("req_ready", 128'(req_ready_o), 128'(expReady));
      checkOutput("busy", 128'(busy_o), 128'(!free));
      if (free && pick >= 0) begin
        e.owner  = pick;
        e.key    = req_key_i[128*pick +: 128];
        e.msg    = req_msg_i[128*pick +: 128];
        e.err    = neverDone || (coreLat + 1 > TO);
        e.plain  = e.err ? 128'h0 : refPlain(e.key, e.msg);
        e.runLen = e.err ? TO : coreLat + 1;
        expQ.push_back(e);
        grantCyc = cyc; runCnt = 0; rr = (pick + 1) % N; free = 1'b0;
      end
      if (aes_start_o) begin
        if (!startPrev && expQ.size() > 0) begin
          checkOutput("start_latency", 128'(cyc - grantCyc), 128'(1 + KS));
          checkOutput("aes_key", aes_key_o, expQ[0].key);
          checkOutput("aes_msg_enc", aes_msg_enc_o, expQ[0].msg);
        end
        runCnt++;
      end
      startPrev = aes_start_o;
      if (draining && !aes_done_i) begin
        free = 1'b1; draining = 1'b0;
      end
      if (rsp_valid_o != '0) begin
        if (expQ.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL rsp_unexpected: got rsp_valid %b expected none", rsp_valid_o);
        end else begin
          expValid = '0;
          expValid[expQ[0].owner] = 1'b1;
          checkOutput("rsp_valid", 128'(rsp_valid_o), 128'(expValid));
          checkOutput("start_low_in_rsp", 128'(aes_start_o), 128'h0);
          if (inResp) begin
            checkOutput("rsp_msg_stable", rsp_msg_o, capMsg);
            checkOutput("rsp_err_stable", 128'(rsp_err_o), 128'(capErr));
          end else begin
            inResp = 1'b1; capMsg = rsp_msg_o; capErr = rsp_err_o;
          end
          if (rsp_ready_i[expQ[0].owner]) begin
            checkOutput("rsp_msg", rsp_msg_o, expQ[0].plain);
            checkOutput("rsp_err", 128'(rsp_err_o), 128'(expQ[0].err));
            checkOutput("run_cycles", 128'(runCnt), 128'(expQ[0].runLen));
            void'(expQ.pop_front());
            inResp = 1'b0; draining = 1'b1;
          end
        end
      end
    end
  end

  logic [N-1:0] reqValid = '0;

  task automatic step();
    logic [N-1:0] seen;
    int           d;
    @(negedge clk);
    seen = req_ready_o;
    @(posedge clk);
    #1;
    reqValid &= ~seen;
    if (dropEn && $urandom_range(0, 15) == 0) begin
      d = $urandom_range(0, N - 1);
      reqValid[d] = 1'b0;
    end
    req_valid_i = reqValid;
  endtask

  task automatic runUntilIdle(input int limit);
    int n = 0;
    while (n < limit && !(reqValid == '0 && expQ.size() == 0 && !busy_o)) begin
      step();
      n++;
    end
    if (n >= limit) begin
      total++; bad++;
      $display("[TB] FAIL idle_wait: got still busy after %0d cycles expected idle", limit);
    end
  endtask

  task automatic issueOne(input int i, input logic [127:0] k, input logic [127:0] m);
    reqValid[i] = 1'b1;
    req_key_i[128*i +: 128] = k;
    req_msg_i[128*i +: 128] = m;
    req_valid_i = reqValid;
  endtask

  task automatic applyStimulus(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      if (mask[i]) issueOne(i, {$urandom, $urandom, $urandom, $urandom},
                               {$urandom, $urandom, $urandom, $urandom});
    end
    runUntilIdle(3000);
  endtask

  initial begin
    int n;
    req_valid_i = '0; req_key_i = '0; req_msg_i = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_req_ready", 128'(req_ready_o), 128'h0);
    checkOutput("reset_rsp_valid", 128'(rsp_valid_o), 128'h0);
    checkOutput("reset_rsp_msg", rsp_msg_o, 128'h0);
    checkOutput("reset_rsp_err", 128'(rsp_err_o), 128'h0);
    checkOutput("reset_aes_start", 128'(aes_start_o), 128'h0);
    checkOutput("reset_aes_key", aes_key_o, 128'h0);
    checkOutput("reset_aes_msg_enc", aes_msg_enc_o, 128'h0);
    checkOutput("reset_busy", 128'(busy_o), 128'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] single FIPS-197 request");
    coreLat = 3;
    issueOne(0, FIPS_KEY, FIPS_CT);
    runUntilIdle(500);

    $display("[TB] round-robin fairness and wrap");
    applyStimulus(4'hF);
    applyStimulus(4'h7);
    applyStimulus(4'h4);

    $display("[TB] timeout and DONE-on-last-cycle");
    neverDone = 1'b1;
    applyStimulus(4'h2);
    neverDone = 1'b0;
    coreLat = TO - 1;
    applyStimulus(4'h8);
    coreLat = TO;
    applyStimulus(4'h1);
    coreLat = 2;

    $display("[TB] response backpressure");
    rspDelay = 20;
    applyStimulus(4'h3);
    rspDelay = 0;

    $display("[TB] reset during RUN");
    neverDone = 1'b1;
    issueOne(1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    n = 0;
    while (!aes_start_o && n < 100) begin
      step();
      n++;
    end
    checkOutput("reached_run", 128'(aes_start_o), 128'h1);
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_aes_start", 128'(aes_start_o), 128'h0);
    checkOutput("midreset_busy", 128'(busy_o), 128'h0);
    checkOutput("midreset_rsp_valid", 128'(rsp_valid_o), 128'h0);
    reqValid = '0;
    req_valid_i = '0;
    neverDone = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(N'(1 << $urandom_range(0, N - 1)));

    $display("[TB] slow DONE release");
    coreHold = 5;
    applyStimulus(4'hF);
    coreHold = 0;

    $display("[TB] randomized traffic");
    dropEn = 1'b1;
    repeat (40) begin
      coreLat   = $urandom_range(0, TO);
      coreHold  = $urandom_range(0, 3);
      rspDelay  = $urandom_range(0, 4);
      neverDone = ($urandom_range(0, 9) == 0);
      applyStimulus(N'($urandom_range(1, 15)));
    end
    dropEn = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
